// File: rtl/io_result_collector_if.sv
// Host-side output stream of the result collector.
// Carries the FIFO head word and its valid/ready handshake.
interface io_result_collector_if #(
    parameter int WIDTH = 36
) ();
    logic [WIDTH-1:0] dataOut;
    logic             dataValid;
    logic             dataReady;

    modport master (
        output dataOut,
        output dataValid,
        input  dataReady
    );

    modport slave (
        input  dataOut,
        input  dataValid,
        output dataReady
    );
endinterface

// File: rtl/io_result_collector.sv
// Host-side I/O endpoint: arms a processor run, captures its output words
// into a FIFO and hands them to the host over a valid/ready stream.
module io_result_collector #(
    parameter int WIDTH      = 36,
    parameter int DEPTH      = 8,
    parameter int PTRWIDTH   = 3,
    parameter int COUNTWIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hostStart,
    input  logic                  hostAbort,
    input  logic [COUNTWIDTH-1:0] expectedWords,
    input  logic                  outFlagIO,
    input  logic [WIDTH-1:0]      cpuOut,
    output logic                  startIO,
    io_result_collector_if.master host,
    output logic [COUNTWIDTH-1:0] wordCount,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } stateT;

    localparam logic [PTRWIDTH:0] FULLCOUNT = (PTRWIDTH + 1)'(DEPTH);

    stateT state;
    stateT stateNext;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PTRWIDTH-1:0]   rdPtr;
    logic [PTRWIDTH-1:0]   wrPtr;
    logic [PTRWIDTH:0]     count;
    logic [COUNTWIDTH-1:0] expLatched;
    logic [COUNTWIDTH-1:0] wordNext;

    logic startRun;
    logic capture;
    logic fifoEmpty;
    logic fifoFull;
    logic pop;
    logic push;
    logic drop;
    logic hitCount;
    logic lastPop;

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == FULLCOUNT);
    assign startRun  = hostStart && (state == IDLE || state == DONE);
    assign capture   = (state == RUN) && outFlagIO;
    assign pop       = !fifoEmpty && host.dataReady;
    // A full FIFO can still accept a word when the head leaves this cycle.
    assign push      = capture && (!fifoFull || pop);
    assign drop      = capture && fifoFull && !pop;
    assign lastPop   = (count == (PTRWIDTH + 1)'(1)) && pop;

    assign wordNext = (wordCount == '1) ? wordCount
                                        : wordCount + COUNTWIDTH'(1);
    assign hitCount = capture && (expLatched != '0)
                      && (wordNext == expLatched);

    assign host.dataValid = !fifoEmpty;
    assign host.dataOut   = fifoEmpty ? '0 : mem[rdPtr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (startRun) stateNext = RUN;
            RUN:     if (hitCount || hostAbort) stateNext = DRAIN;
            DRAIN:   if (fifoEmpty || lastPop) stateNext = DONE;
            DONE:    if (startRun) stateNext = RUN;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        startIO = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            RUN: begin
                startIO = 1'b1;
                busy    = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            wordCount  <= '0;
            overflow   <= 1'b0;
            expLatched <= '0;
        end else if (startRun) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            wordCount  <= '0;
            overflow   <= 1'b0;
            expLatched <= expectedWords;
        end else begin
            if (push) wrPtr <= wrPtr + PTRWIDTH'(1);
            if (pop) rdPtr <= rdPtr + PTRWIDTH'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PTRWIDTH + 1)'(1);
                2'b01:   count <= count - (PTRWIDTH + 1)'(1);
                default: ;
            endcase
            if (capture) wordCount <= wordNext;
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= cpuOut;
        end
    end

endmodule

// File: tb/tb_io_result_collector.sv
// Directed self-checking bench for io_result_collector.
// Each task drives one scenario and checks responses inline.
module tb_io_result_collector;

    logic        clock;
    logic        reset;
    logic        hostStart;
    logic        hostAbort;
    logic [15:0] expectedWords;
    logic        outFlagIO;
    logic [35:0] cpuOut;
    logic        startIO;
    logic [15:0] wordCount;
    logic        overflow;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    io_result_collector_if #(.WIDTH(36)) hostIf ();

    io_result_collector #(
        .WIDTH(36),
        .DEPTH(8),
        .PTRWIDTH(3),
        .COUNTWIDTH(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hostStart(hostStart),
        .hostAbort(hostAbort),
        .expectedWords(expectedWords),
        .outFlagIO(outFlagIO),
        .cpuOut(cpuOut),
        .startIO(startIO),
        .host(hostIf.master),
        .wordCount(wordCount),
        .overflow(overflow),
        .busy(busy),
        .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic startRun(input logic [15:0] n);
        expectedWords = n;
        hostStart = 1'b1;
        tick();
        hostStart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        checks++;
        if ({startIO, busy, done, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {startIO, busy, done, overflow});
        end
        checks++;
        if ({hostIf.dataValid, hostIf.dataOut, wordCount} !== 53'd0) begin
            errors++;
            $display("FAIL reset_data valid=%b out=%h cnt=%0d exp=0",
                     hostIf.dataValid, hostIf.dataOut, wordCount);
        end
        outFlagIO = 1'b1;
        cpuOut = 36'h5;
        tick();
        outFlagIO = 1'b0;
        checks++;
        if (hostIf.dataValid !== 1'b0 || wordCount !== 16'd0) begin
            errors++;
            $display("FAIL idle_flag valid=%b cnt=%0d exp=0,0",
                     hostIf.dataValid, wordCount);
        end
    endtask

    task automatic test_basic_run();
        hostIf.dataReady = 1'b1;
        startRun(16'd3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got=%b exp=1", busy);
        end
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (startIO !== 1'b1) begin
                errors++;
                $display("FAIL basic_startio%0d got=%b exp=1", i, startIO);
            end
            outFlagIO = 1'b1;
            cpuOut = 36'(i);
            tick();
            checks++;
            if (hostIf.dataValid !== 1'b1 || hostIf.dataOut !== 36'(i)) begin
                errors++;
                $display("FAIL basic_word%0d got=%b/%h exp=1/%h",
                         i, hostIf.dataValid, hostIf.dataOut, 36'(i));
            end
        end
        // This pulse lands in DRAIN and must be ignored.
        cpuOut = 36'h99;
        checks++;
        if (startIO !== 1'b0) begin
            errors++;
            $display("FAIL basic_startio_drop got=%b exp=0", startIO);
        end
        tick();
        outFlagIO = 1'b0;
        checks++;
        if ({done, overflow, hostIf.dataValid} !== 3'b100
            || wordCount !== 16'd3) begin
            errors++;
            $display("FAIL basic_end dov=%b cnt=%0d exp=100,3",
                     {done, overflow, hostIf.dataValid}, wordCount);
        end
    endtask

    task automatic test_full_push_pop();
        logic [35:0] exp [12];
        for (int i = 0; i < 8; i++) exp[i] = 36'h10 + 36'(i);
        for (int i = 0; i < 4; i++) exp[8 + i] = 36'hA + 36'(i);
        hostIf.dataReady = 1'b0;
        startRun(16'd12);
        for (int i = 0; i < 8; i++) begin
            outFlagIO = 1'b1;
            cpuOut = exp[i];
            tick();
        end
        hostIf.dataReady = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cpuOut = exp[8 + j];
            checks++;
            if (hostIf.dataOut !== exp[j]) begin
                errors++;
                $display("FAIL full_pp%0d got=%h exp=%h",
                         j, hostIf.dataOut, exp[j]);
            end
            tick();
        end
        outFlagIO = 1'b0;
        for (int j = 4; j < 12; j++) begin
            checks++;
            if (hostIf.dataValid !== 1'b1 || hostIf.dataOut !== exp[j]) begin
                errors++;
                $display("FAIL full_drain%0d got=%b/%h exp=1/%h",
                         j, hostIf.dataValid, hostIf.dataOut, exp[j]);
            end
            tick();
        end
        hostIf.dataReady = 1'b0;
        checks++;
        if ({done, overflow} !== 2'b10 || wordCount !== 16'd12) begin
            errors++;
            $display("FAIL full_end do=%b cnt=%0d exp=10,12",
                     {done, overflow}, wordCount);
        end
    endtask

    task automatic test_overflow();
        hostIf.dataReady = 1'b0;
        startRun(16'd10);
        for (int i = 0; i < 10; i++) begin
            outFlagIO = 1'b1;
            cpuOut = 36'(i);
            tick();
            if (i == 7) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early got=%b exp=0", overflow);
                end
            end
            if (i == 8) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_set got=%b exp=1", overflow);
                end
            end
        end
        outFlagIO = 1'b0;
        checks++;
        if ({busy, done, startIO} !== 3'b100 || wordCount !== 16'd10) begin
            errors++;
            $display("FAIL ovf_drain bds=%b cnt=%0d exp=100,10",
                     {busy, done, startIO}, wordCount);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_hold bd=%b%b exp=10", busy, done);
        end
        hostIf.dataReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy !== 1'b1 || hostIf.dataOut !== 36'(i)) begin
                errors++;
                $display("FAIL ovf_pop%0d busy=%b got=%h exp=1/%h",
                         i, busy, hostIf.dataOut, 36'(i));
            end
            tick();
        end
        hostIf.dataReady = 1'b0;
        checks++;
        if (done !== 1'b1 || hostIf.dataValid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done d=%b v=%b o=%b exp=1,0,1",
                     done, hostIf.dataValid, overflow);
        end
    endtask

    task automatic test_abort_restart();
        hostIf.dataReady = 1'b0;
        startRun(16'd0);
        checks++;
        if (overflow !== 1'b0 || wordCount !== 16'd0) begin
            errors++;
            $display("FAIL abort_clear o=%b cnt=%0d exp=0,0",
                     overflow, wordCount);
        end
        outFlagIO = 1'b1;
        cpuOut = 36'h21;
        tick();
        cpuOut = 36'h22;
        hostAbort = 1'b1;
        tick();
        outFlagIO = 1'b0;
        hostAbort = 1'b0;
        checks++;
        if ({startIO, busy, done} !== 3'b010 || wordCount !== 16'd2) begin
            errors++;
            $display("FAIL abort_drain sbd=%b cnt=%0d exp=010,2",
                     {startIO, busy, done}, wordCount);
        end
        hostIf.dataReady = 1'b1;
        checks++;
        if (hostIf.dataOut !== 36'h21) begin
            errors++;
            $display("FAIL abort_pop0 got=%h exp=21", hostIf.dataOut);
        end
        tick();
        checks++;
        if (hostIf.dataOut !== 36'h22 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_pop1 got=%h d=%b exp=22,0",
                     hostIf.dataOut, done);
        end
        tick();
        hostIf.dataReady = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_done got=%b exp=1", done);
        end
        startRun(16'd0);
        checks++;
        if ({startIO, busy, done, overflow} !== 4'b1100
            || wordCount !== 16'd0) begin
            errors++;
            $display("FAIL restart sbdo=%b cnt=%0d exp=1100,0",
                     {startIO, busy, done, overflow}, wordCount);
        end
    endtask

    task automatic test_reset_midrun();
        hostIf.dataReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            outFlagIO = 1'b1;
            cpuOut = 36'h30 + 36'(i);
            tick();
        end
        outFlagIO = 1'b0;
        checks++;
        if (hostIf.dataValid !== 1'b1 || wordCount !== 16'd5) begin
            errors++;
            $display("FAIL mid_fill v=%b cnt=%0d exp=1,5",
                     hostIf.dataValid, wordCount);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if ({hostIf.dataValid, startIO, busy, done} !== 4'b0000
            || wordCount !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset vsbd=%b cnt=%0d exp=0000,0",
                     {hostIf.dataValid, startIO, busy, done}, wordCount);
        end
    endtask

    initial begin
        reset = 1'b0;
        hostStart = 1'b0;
        hostAbort = 1'b0;
        expectedWords = 16'd0;
        outFlagIO = 1'b0;
        cpuOut = '0;
        hostIf.dataReady = 1'b0;
        test_reset();
        test_basic_run();
        test_full_push_pop();
        test_overflow();
        test_abort_restart();
        test_reset_midrun();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_result_collector.md
# io_result_collector

Host-side I/O endpoint for the pipelined processor's output port. It arms a run by driving `startIO`, captures every word the processor emits on its output bus while the output flag is high, and buffers those words in a FIFO. The buffered words are handed to the host over a valid/ready handshake. It sits between the processor top level and the external test or host logic, and terminates the processor's output path.

## Interface
- `WIDTH`, 36: data word width; matches the processor datapath.
- `DEPTH`, 8: FIFO entries; must be a power of two and ≥ 2.
- `PTRWIDTH`, 3: log2(`DEPTH`).
- `COUNTWIDTH`, 16: width of the word counter and the expected-word count.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `hostStart`  in  1  request to begin a run; sampled in IDLE or DONE only.
- `hostAbort`  in  1  ends the current run early; sampled in RUN only.
- `expectedWords`  in  `COUNTWIDTH`  number of output words that end a run; latched on start; 0 means unlimited (run ends only on abort).
- `outFlagIO`  in  1  processor output-valid flag.
- `cpuOut`  in  `WIDTH`  processor output word.
- `startIO`  out  1  drives the processor's `startIO`; high throughout RUN.
- `dataOut`  out  `WIDTH`  FIFO head word.
- `dataValid`  out  1  FIFO not empty.
- `dataReady`  in  1  host accepts `dataOut` when `dataValid` and `dataReady` are both high.
- `wordCount`  out  `COUNTWIDTH`  captures attempted this run, including dropped words.
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  state is DONE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on `hostStart` → RUN. In the same edge, latch `expectedWords`, clear `wordCount` and `overflow`, and reset the FIFO pointers.
  - RUN: `startIO` = 1. Capture occurs on every cycle with `outFlagIO` = 1. `hostStart` is ignored.
    - Go to DRAIN when a capture makes `wordCount` equal the latched nonzero expected value.
    - Go to DRAIN when `hostAbort` = 1. If the abort coincides with a capture, the word is still captured.
  - DRAIN: `startIO` = 0; captures are ignored. Go to DONE on the edge at which the FIFO becomes empty, or immediately if it is already empty.
  - DONE: `done` = 1; the FIFO is empty. On `hostStart` → RUN, with the same clearing as from IDLE.
- FIFO:
  - Circular buffer indexed by `PTRWIDTH`-bit read and write pointers that wrap modulo `DEPTH`.
  - A separate occupancy counter, `PTRWIDTH`+1 bits, distinguishes full from empty.
  - Push: a capture is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Full with no pop: the word is dropped, `overflow` is set to 1, and `wordCount` still increments.
  - Pop: when `dataValid` && `dataReady`. Pops are allowed in RUN, DRAIN, IDLE and DONE.
  - Simultaneous push and pop leaves occupancy unchanged.
- `wordCount` saturates at all-ones; it does not wrap.
- `dataOut` is the entry at the read pointer, taken from storage with no extra register stage. Its value is don't-care when `dataValid` = 0.

## Timing
- Reset (while `reset` = 0 at an edge):
  - FSM goes to IDLE; FIFO empties.
  - `startIO` = 0, `dataValid` = 0, `dataOut` = 0, `wordCount` = 0, `overflow` = 0, `busy` = 0, `done` = 0.
  - Reset mid-run discards all buffered words and drops `startIO` after that edge.
- `hostStart` high at edge N in IDLE: `startIO` = 1 and `busy` = 1 in the cycle after edge N.
- A capture at edge N in RUN: `dataValid` = 1 and the word is on `dataOut` in the cycle after edge N, so capture-to-output latency is 1 cycle.
- The final expected capture at edge N: `startIO` = 0 after edge N. A flag pulse in that next cycle is not captured.
- DRAIN → DONE: `done` rises the cycle after the last pop.
- Full throughput: one push and one pop per cycle sustained with no loss.

## Test plan
- Reset behaviour: assert `reset` = 0 for 2 cycles, then release. All outputs read 0 and the FSM is in IDLE. Pulsing `outFlagIO` with `cpuOut` = 36'h5 in IDLE leaves `dataValid` = 0 and `wordCount` = 0.
- Basic run: `expectedWords` = 3, `hostStart` pulse, then flags carrying 36'h1, 36'h2, 36'h3 with `dataReady` = 1. Required response:
  - `startIO` is high from the cycle after start through the third capture.
  - The host receives 1, 2, 3 in order.
  - `done` = 1; `overflow` = 0; `wordCount` = 3.
- Overflow: `dataReady` = 0, `expectedWords` = 10, 10 consecutive flags carrying values 0–9. Required response:
  - The FIFO holds 0–7.
  - `overflow` = 1 after the ninth capture; `wordCount` = 10.
  - The state is DRAIN until the host pops all 8 words, then DONE.
- Full with simultaneous push and pop: fill the FIFO to 8, then hold `dataReady` = 1 while flags continue for 4 more cycles with values A–D. Required response: no drop, `overflow` = 0, and the output order is preserved across pointer wrap.
- Abort and restart: `expectedWords` = 0, capture 2 words, then `hostAbort`. Required response:
  - The state goes to DRAIN and `startIO` drops.
  - After the host pops both words, `done` = 1.
  - A new `hostStart` clears `wordCount` and `overflow` and raises `startIO` again.
- Reset mid-run: with 5 words buffered, assert `reset` = 0 for one edge. Required response: `dataValid` = 0, `startIO` = 0, and the FSM is in IDLE.
